// File: rtl/sample_arb_pkg.sv
// Shared types and helpers for the wave-table sample read arbiter.
package sample_arb_pkg;

  // Tag index is fixed-width so the struct can live here; covers up to 256 requesters.
  localparam int TAG_IDX_WIDTH = 8;

  function automatic int req_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [TAG_IDX_WIDTH-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_picker
  import sample_arb_pkg::*;
#(
  parameter int N     = 6,
  parameter int IDX_W = req_idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = '0;
    for (int off = 1; off <= N; off++) begin
      c = IDX_W'((int'(ptr) + off) % N);
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = c;
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_read_arbiter.sv
// Round-robin arbiter sharing the wave-table BRAM read port; tags ride a shift
// register aligned with BRAM latency. Define SAMPLE_ARB_OSC_PRIO_EN for oscillator priority.
module sample_read_arbiter
  import sample_arb_pkg::*;
#(
  parameter int NUM_REQ      = 6,
  parameter int NUM_OSC      = 4,
  parameter int ADDR_WIDTH   = 18,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic                                   hold_in,
  input  logic [NUM_REQ-1:0]                     req_in,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_in,
  output logic [NUM_REQ-1:0]                     busy_out,
  output logic [NUM_REQ-1:0]                     rvalid_out,
  output logic [NUM_REQ-1:0][SAMPLE_WIDTH-1:0]   rdata_out,
  output logic                                   bram_en_out,
  output logic [ADDR_WIDTH-1:0]                  bram_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]                bram_data_in
);

  localparam int RW = req_idx_width(NUM_REQ);

  if (NUM_OSC < 1 || NUM_OSC >= NUM_REQ || BRAM_LATENCY < 1) begin : g_bad_cfg
    $error("sample_read_arbiter: NUM_OSC must be 1..NUM_REQ-1 and BRAM_LATENCY >= 1");
  end

  logic [NUM_REQ-1:0] elig, gnt, ret_vec;
  logic [RW-1:0]      win;
  logic               any;
  tag_t               tag_pipe [BRAM_LATENCY:0];

  // Hold suppresses eligibility, so pickers report no grant and pointers stay put.
  assign elig = req_in & ~busy_out & {NUM_REQ{~hold_in}};

`ifdef SAMPLE_ARB_OSC_PRIO_EN
  localparam int NOTH = NUM_REQ - NUM_OSC;
  localparam int OW   = req_idx_width(NUM_OSC);
  localparam int TW   = req_idx_width(NOTH);

  logic [OW-1:0]      osc_ptr, osc_idx;
  logic [TW-1:0]      oth_ptr, oth_idx;
  logic [NUM_OSC-1:0] osc_gnt;
  logic [NOTH-1:0]    oth_gnt;
  logic               osc_any, oth_any;

  rr_picker #(.N(NUM_OSC), .IDX_W(OW)) u_osc_pick (
    .req(elig[NUM_OSC-1:0]), .ptr(osc_ptr), .gnt(osc_gnt), .idx(osc_idx), .any(osc_any)
  );
  rr_picker #(.N(NOTH), .IDX_W(TW)) u_oth_pick (
    .req(elig[NUM_REQ-1:NUM_OSC]), .ptr(oth_ptr), .gnt(oth_gnt), .idx(oth_idx), .any(oth_any)
  );

  // Any eligible oscillator shadows viz/debug entirely.
  assign any = osc_any | oth_any;
  assign win = osc_any ? RW'(osc_idx) : RW'(NUM_OSC + int'(oth_idx));
  assign gnt = osc_any ? {{NOTH{1'b0}}, osc_gnt} : {oth_gnt, {NUM_OSC{1'b0}}};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      osc_ptr <= OW'(NUM_OSC - 1);
      oth_ptr <= TW'(NOTH - 1);
    end else if (osc_any) begin
      osc_ptr <= osc_idx;
    end else if (oth_any) begin
      oth_ptr <= oth_idx;
    end
  end
`else
  logic [RW-1:0] rr_ptr;

  rr_picker #(.N(NUM_REQ), .IDX_W(RW)) u_pick (
    .req(elig), .ptr(rr_ptr), .gnt(gnt), .idx(win), .any(any)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in)   rr_ptr <= RW'(NUM_REQ - 1);
    else if (any) rr_ptr <= win;
  end
`endif

  always_comb begin
    ret_vec = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ret_vec[i] = tag_pipe[BRAM_LATENCY].valid &&
                   (tag_pipe[BRAM_LATENCY].idx == TAG_IDX_WIDTH'(i));
  end

  // Stage 0 sits alongside bram_en; stage BRAM_LATENCY lines up with bram_data_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_out      <= '0;
      rvalid_out    <= '0;
      rdata_out     <= '0;
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      for (int s = 0; s <= BRAM_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      bram_en_out <= any;
      if (any) bram_addr_out <= addr_in[win];
      tag_pipe[0] <= '{valid: any, idx: TAG_IDX_WIDTH'(win)};
      for (int s = 1; s <= BRAM_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
      busy_out   <= (busy_out & ~ret_vec) | gnt;
      rvalid_out <= ret_vec;
      for (int i = 0; i < NUM_REQ; i++)
        if (ret_vec[i]) rdata_out[i] <= bram_data_in;
    end
  end

endmodule

// File: tb/tb_sample_read_arbiter.sv
// Self-checking bench: cycle model of grants/returns plus a scoreboard of expected read data.
module tb_sample_read_arbiter;

  localparam int NR = 6;
  localparam int NO = 4;
  localparam int AW = 18;
  localparam int SW = 16;
  localparam int L  = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in, hold_in;
  logic [NR-1:0]        req_in;
  logic [NR-1:0][AW-1:0] addr_in;
  logic [NR-1:0]        busy_out, rvalid_out;
  logic [NR-1:0][SW-1:0] rdata_out;
  logic                 bram_en_out;
  logic [AW-1:0]        bram_addr_out;
  logic [SW-1:0]        bram_data_in;

  sample_read_arbiter #(
    .NUM_REQ(NR), .NUM_OSC(NO), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .BRAM_LATENCY(L)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hold_in(hold_in), .req_in(req_in), .addr_in(addr_in),
    .busy_out(busy_out), .rvalid_out(rvalid_out), .rdata_out(rdata_out),
    .bram_en_out(bram_en_out), .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: data word is the low bits of the address, L cycles after the enable cycle.
  logic [AW-1:0] bpipe [L];
  always @(posedge clk_in) begin
    bpipe[0] <= bram_en_out ? bram_addr_out : 18'h2BAD5;
    for (int s = 1; s < L; s++) bpipe[s] <= bpipe[s-1];
  end
  assign bram_data_in = bpipe[L-1][SW-1:0];

  typedef struct { int idx; logic [SW-1:0] data; } exp_t;
  exp_t          sb [$];
  int            checks = 0, failures = 0;
  int            rem [NR];
  logic [NR-1:0] mbusy, exp_rv;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [SW-1:0] mrdata [NR];
  int            mptr, optr, rptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] e);
`ifdef SAMPLE_ARB_OSC_PRIO_EN
    for (int off = 1; off <= NO; off++)
      if (e[(optr + off) % NO]) return (optr + off) % NO;
    for (int off = 1; off <= NR - NO; off++)
      if (e[NO + (rptr + off) % (NR - NO)]) return NO + (rptr + off) % (NR - NO);
`else
    for (int off = 1; off <= NR; off++)
      if (e[(mptr + off) % NR]) return (mptr + off) % NR;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    mbusy = '0; exp_rv = '0; exp_en = 1'b0; exp_addr = '0;
    mptr = NR - 1; optr = NO - 1; rptr = NR - NO - 1;
    for (int i = 0; i < NR; i++) begin rem[i] = 0; mrdata[i] = '0; end
    sb.delete();
  endtask

  // One clock: predict the grant from current inputs, advance model, then compare.
  task automatic tick();
    logic [NR-1:0] e;
    logic [AW-1:0] a;
    exp_t          x;
    int            w;
    e = req_in & ~mbusy & {NR{~hold_in}};
    w = rst_in ? -1 : pick(e);
    a = (w >= 0) ? addr_in[w] : '0;
    @(posedge clk_in); #1;
    if (rst_in) model_reset();
    else begin
      exp_rv = '0;
      for (int i = 0; i < NR; i++)
        if (mbusy[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin mbusy[i] = 1'b0; exp_rv[i] = 1'b1; end
        end
      for (int i = 0; i < NR; i++)
        if (exp_rv[i]) begin
          if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
          else begin
            x = sb.pop_front();
            chk("ret_idx", i, x.idx);
            mrdata[i] = x.data;
          end
        end
      if (w >= 0) begin
        mbusy[w] = 1'b1; rem[w] = L + 1;
        sb.push_back('{w, a[SW-1:0]});
        exp_addr = a;
        if (w < NO) optr = w; else rptr = w - NO;
        mptr = w;
      end
      exp_en = (w >= 0);
    end
    chk("bram_en", bram_en_out, exp_en);
    chk("bram_addr", bram_addr_out, exp_addr);
    chk("busy", busy_out, mbusy);
    chk("rvalid", rvalid_out, exp_rv);
    for (int i = 0; i < NR; i++) chk("rdata", rdata_out[i], mrdata[i]);
  endtask

  task automatic rand_addr();
    for (int i = 0; i < NR; i++) addr_in[i] = AW'($urandom);
  endtask

  initial begin
    model_reset();
    rst_in = 1'b1; hold_in = 1'b0; req_in = '0; addr_in = '0;
    repeat (2) tick();
    rst_in = 1'b0;

    // single request, requester 0
    addr_in[0] = 18'h00010; req_in = 6'b000001;
    tick();
    chk("single_en", bram_en_out, 1);
    chk("single_addr", bram_addr_out, 18'h00010);
    req_in = '0;
    repeat (3) tick();
    chk("single_rvalid", rvalid_out, 6'b000001);
    chk("single_rdata", rdata_out[0], 16'h0010);
    repeat (2) tick();

    // everyone requesting continuously
    req_in = '1;
    repeat (30) begin rand_addr(); tick(); end
    req_in = '0;
    repeat (6) tick();

    // hold after grants to 1 and 2
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    rand_addr(); req_in = 6'b000110;
    repeat (2) tick();
    hold_in = 1'b1; req_in = '1;
    repeat (6) tick();
    hold_in = 1'b0;
    tick();
    chk("hold_resume", bram_addr_out, addr_in[3]);
    req_in = '0;
    repeat (8) tick();

    // reset one cycle after grant to 4
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    rand_addr(); req_in = 6'b010000;
    tick();
    req_in = '0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0; req_in = '1;
    tick();
    chk("post_rst_grant", bram_addr_out, addr_in[0]);
    req_in = '0;
    repeat (8) tick();

    // oscillators plus debug contending
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    req_in = 6'b101111;
    repeat (24) begin rand_addr(); tick(); end
    req_in = '0;
    repeat (6) tick();

    // max address, request dropped right after grant
    addr_in[2] = 18'h3FFFF; req_in = 6'b000100;
    tick();
    req_in = '0;
    repeat (5) tick();
    chk("max_addr_rdata", rdata_out[2], 16'hFFFF);

    // random traffic
    repeat (80) begin
      rand_addr();
      req_in  = NR'($urandom);
      hold_in = ($urandom_range(7) == 0);
      tick();
    end
    req_in = '0; hold_in = 1'b0;
    repeat (10) tick();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
